free_list: RTL and testbench
============================

// Module: free_list
// PURPOSE
//  Circular FIFO of free physical register tags for the R10K-style rename path.
//  Supplies T_new to the ROB and Map Table at dispatch, one tag per cycle.
//  Takes back T_old (ROB T_free, gated by T_out_valid) at retire.
//  Recovers speculative allocations on branch_not_taken by snapping the read
//  pointer back to the retirement-order pointer.
// PARAMETERS
//  NUM_PREGS  64  physical registers; tags are 6 bits, PHYS_REG bit 6 is the ready bit
//  NUM_AREGS  32  architectural registers, mapped at reset to physical tags 0..31
//  FL_SIZE    NUM_PREGS-NUM_AREGS (32)  free list depth; must be a power of 2
// PORTS
//  clock             in   1   clock
//  reset             in   1   synchronous, active-high
//  enable            in   1   0 = freeze all state (reset still applies)
//  dispatch_en       in   1   pop request (one rename per cycle)
//  retire_en         in   1   push request (ROB T_out_valid)
//  T_free_in         in   7   tag to free (ROB T_free); bit 6 ignored
//  branch_not_taken  in   1   mispredict flush; same cycle the ROB clears
//  T_new_out         out  7   {1'b0, list[head]}; 7'h7F when empty
//  free_valid        out  1   T_new_out is valid and a pop will be taken
//  fl_empty          out  1   no free tags; dispatch must stall
//  free_entries      out  clog2(FL_SIZE)+1   count = tail - head
// BEHAVIOUR
//  State
//   - list[FL_SIZE] x 6 bits.
//   - head, tail, arch_head: each clog2(FL_SIZE)+1 bits (extra wrap bit).
//   - empty = (head == tail); full = (idx equal, wrap bits differ).
//  Reset
//   - list[i] = NUM_AREGS+i; head = tail = arch_head = 0, wrap bit of tail = 1 (full).
//   - Outputs after reset: T_new_out = 7'h20, free_valid = 1, fl_empty = 0,
//     free_entries = 32.
//  Outputs are combinational from registered state: zero-latency read of list[head].
//  Pop
//   - Taken when dispatch_en & enable & !empty & !branch_not_taken; head += 1.
//   - Pop while empty is ignored: no state change, T_new_out = 7'h7F.
//  Push
//   - When retire_en & enable: list[tail] = T_free_in[5:0]; tail += 1;
//     arch_head += 1 (the retiring instruction's T_new was allocated at arch_head).
//   - Push while full is dropped; cannot occur in a correct pipeline.
//  Push and pop in the same cycle
//   - Both occur; count unchanged.
//   - No bypass: if empty at cycle start, the pop is refused even with a
//     simultaneous push; the pushed tag is available next cycle.
//  Flush (branch_not_taken & enable)
//   - Retire push of the same cycle is performed first (tail and arch_head advance).
//   - Then head = updated arch_head; any dispatch_en that cycle is ignored.
//   - Result: every tag popped but not yet retired is free again.
//  Wrap-around: index = ptr[clog2-1:0]; pointers roll modulo 2*FL_SIZE, no special case.
//  Invariant: arch_head is in [head_prev_flush, head], and free_entries <= FL_SIZE at all times.
//  Reset mid-operation: overrides push/pop/flush that cycle; full reset state next cycle.
// TESTING
//  1 Reset -> T_new_out=7'h20, free_entries=32, fl_empty=0; 32 pops give 0x20..0x3F
//    in order, then fl_empty=1, T_new_out=7'h7F.
//  2 Empty, then push 0x05 with dispatch_en in the same cycle -> pop refused;
//    next cycle T_new_out=7'h05, free_entries=1.
//  3 From reset: pop 3 (0x20,0x21,0x22), retire 1 with T_free_in=0x03, then flush
//    -> head=1, T_new_out=7'h21, free_entries=32, list[0] now holds 0x03.
//  4 Flush with simultaneous retire and dispatch_en -> retire counted, pop ignored,
//    head equals new arch_head.
//  5 Steady state 100 cycles of push+pop across the wrap boundary -> free_entries
//    constant; tags emerge in push order.
//  6 reset asserted mid-stream with enable=0 and dispatch_en=1 -> reset state next
//    cycle; enable=0 alone freezes all outputs.

Source files
------------

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags for the rename stage.
// Pops T_new at dispatch, pushes T_old at retire, rewinds to retirement order on a flush.
module free_list #(
  parameter  int NUM_PREGS = 64,
  parameter  int NUM_AREGS = 32,
  localparam int FL_SIZE   = NUM_PREGS - NUM_AREGS,
  localparam int IDX_W     = $clog2(FL_SIZE),
  localparam int PTR_W     = IDX_W + 1,
  localparam int TAG_W     = $clog2(NUM_PREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             dispatch_en,
  input  logic             retire_en,
  input  logic [TAG_W:0]   T_free_in,
  input  logic             branch_not_taken,
  output logic [TAG_W:0]   T_new_out,
  output logic             free_valid,
  output logic             fl_empty,
  output logic [PTR_W-1:0] free_entries
);

  logic [TAG_W-1:0] list_q [FL_SIZE];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] arch_head_q, arch_head_d;
  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic             unused_tag_bit_s;

  // The ready bit of the freed tag carries no meaning inside the list.
  assign unused_tag_bit_s = T_free_in[TAG_W];

  assign empty_s = (head_q == tail_q);
  assign full_s  = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                   (head_q[IDX_W] != tail_q[IDX_W]);
  assign push_s  = enable & retire_en & ~full_s;
  assign pop_s   = enable & dispatch_en & ~empty_s & ~branch_not_taken;

  // Next-state pointers; a flush rewinds head to arch_head after this cycle's retire.
  always_comb begin
    tail_d      = tail_q;
    arch_head_d = arch_head_q;
    head_d      = head_q;
    if (push_s) begin
      tail_d      = tail_q + PTR_W'(1);
      arch_head_d = arch_head_q + PTR_W'(1);
    end else begin
      tail_d      = tail_q;
      arch_head_d = arch_head_q;
    end
    if (enable && branch_not_taken) begin
      head_d = arch_head_d;
    end else if (pop_s) begin
      head_d = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
  end

  // Pointer registers; reset leaves the list full.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= {1'b1, IDX_W'(0)};
    end else begin
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
    end
  end

  // Tag storage; reset loads the tags not held by the architectural map.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        list_q[i] <= TAG_W'(NUM_AREGS + i);
      end
    end else if (push_s) begin
      list_q[tail_q[IDX_W-1:0]] <= T_free_in[TAG_W-1:0];
    end else begin
      list_q <= list_q;
    end
  end

  // Zero-latency read of the head entry.
  always_comb begin
    if (empty_s) begin
      T_new_out = {(TAG_W + 1){1'b1}};
    end else begin
      T_new_out = {1'b0, list_q[head_q[IDX_W-1:0]]};
    end
  end

  assign free_valid   = ~empty_s;
  assign fl_empty     = empty_s;
  assign free_entries = tail_q - head_q;

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: queue-based model checked every cycle
// plus directed vectors with hand-computed expectations.
module tb_free_list;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       dispatch_en = 1'b0;
  logic       retire_en = 1'b0;
  logic [6:0] T_free_in = 7'h00;
  logic       branch_not_taken = 1'b0;
  logic [6:0] T_new_out;
  logic       free_valid;
  logic       fl_empty;
  logic [5:0] free_entries;

  int errors = 0;
  int checks = 0;
  bit model_on = 1'b0;

  logic [5:0] fl_q[$];
  logic [5:0] spec_q[$];
  logic [5:0] pushed [100];

  free_list dut (
    .clock(clock), .reset(reset), .enable(enable), .dispatch_en(dispatch_en),
    .retire_en(retire_en), .T_free_in(T_free_in), .branch_not_taken(branch_not_taken),
    .T_new_out(T_new_out), .free_valid(free_valid), .fl_empty(fl_empty),
    .free_entries(free_entries)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: free tags in allocation order, and tags allocated but not yet retired.
  task automatic model_update(input logic d, input logic r, input logic [6:0] t,
                              input logic b, input logic e, input logic rs);
    int  sz;
    bit  pop_ok, push_ok;
    logic [5:0] tag;
    if (rs) begin
      fl_q.delete();
      spec_q.delete();
      for (int i = 0; i < 32; i++) fl_q.push_back(6'(32 + i));
    end else if (e) begin
      sz      = fl_q.size();
      pop_ok  = d && (sz > 0) && !b;
      push_ok = r && (sz < 32);
      if (pop_ok) begin
        tag = fl_q.pop_front();
        spec_q.push_back(tag);
      end
      if (push_ok) begin
        fl_q.push_back(t[5:0]);
        if (spec_q.size() > 0) void'(spec_q.pop_front());
      end
      if (b) begin
        fl_q = {spec_q, fl_q};
        spec_q.delete();
      end
    end
  endtask

  task automatic step(input logic d, input logic r, input logic [6:0] t,
                      input logic b, input logic e, input logic rs);
    dispatch_en = d; retire_en = r; T_free_in = t;
    branch_not_taken = b; enable = e; reset = rs;
    @(posedge clock);
    model_update(d, r, t, b, e, rs);
    if (rs) model_on = 1'b1;
    @(negedge clock);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (model_on) begin
      chk("model_T_new_out", T_new_out,
          (fl_q.size() > 0) ? {25'd0, 1'b0, fl_q[0]} : 32'h7F);
      chk("model_free_valid", free_valid, (fl_q.size() > 0) ? 32'd1 : 32'd0);
      chk("model_fl_empty", fl_empty, (fl_q.size() == 0) ? 32'd1 : 32'd0);
      chk("model_free_entries", free_entries, fl_q.size());
    end
  end

  initial begin
    @(negedge clock);

    // 1: reset state and draining the list
    step(1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1);
    chk("rst_T_new_out", T_new_out, 32'h20);
    chk("rst_free_entries", free_entries, 32'd32);
    chk("rst_fl_empty", fl_empty, 32'd0);
    chk("rst_free_valid", free_valid, 32'd1);
    for (int i = 0; i < 32; i++) begin
      chk("drain_tag", T_new_out, 32'h20 + i);
      pop_n(1);
    end
    chk("drained_fl_empty", fl_empty, 32'd1);
    chk("drained_T_new_out", T_new_out, 32'h7F);
    chk("drained_free_entries", free_entries, 32'd0);
    pop_n(1);
    chk("pop_empty_ignored", free_entries, 32'd0);

    // 2: push with dispatch while empty; bit 6 of the freed tag is dropped
    step(1'b1, 1'b1, 7'h45, 1'b0, 1'b1, 1'b0);
    chk("nobypass_T_new_out", T_new_out, 32'h05);
    chk("nobypass_free_entries", free_entries, 32'd1);

    // 3: pop 3, retire 1, flush
    step(1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1);
    pop_n(3);
    chk("t3_after_pops", T_new_out, 32'h23);
    step(1'b0, 1'b1, 7'h03, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0);
    chk("t3_flush_T_new_out", T_new_out, 32'h21);
    chk("t3_flush_free_entries", free_entries, 32'd32);
    pop_n(31);
    chk("t3_list0_tag", T_new_out, 32'h03);
    chk("t3_list0_entries", free_entries, 32'd1);

    // 4: flush together with retire and dispatch
    step(1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1);
    pop_n(2);
    step(1'b1, 1'b1, 7'h10, 1'b1, 1'b1, 1'b0);
    chk("t4_T_new_out", T_new_out, 32'h21);
    chk("t4_free_entries", free_entries, 32'd32);
    pop_n(31);
    chk("t4_pushed_tag", T_new_out, 32'h10);

    // 5: steady push+pop across the wrap boundary
    step(1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1);
    pop_n(4);
    for (int i = 0; i < 100; i++) begin
      pushed[i] = 6'((i * 7 + 3) % 64);
      if (i >= 28) chk("t5_push_order", T_new_out, {26'd0, pushed[i - 28]});
      step(1'b1, 1'b1, {1'b0, pushed[i]}, 1'b0, 1'b1, 1'b0);
      chk("t5_free_entries", free_entries, 32'd28);
    end

    // 6: reset with enable low, then freeze
    pop_n(3);
    step(1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
    chk("t6_rst_T_new_out", T_new_out, 32'h20);
    chk("t6_rst_free_entries", free_entries, 32'd32);
    pop_n(1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 7'h0A, 1'b1, 1'b0, 1'b0);
      chk("t6_frozen_T_new_out", T_new_out, 32'h21);
      chk("t6_frozen_free_entries", free_entries, 32'd31);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
